// File: rtl/lab3_mem_line_mem_responder_pkg.sv
// Shared message types and constants for the 16B line memory responder.
// Message layouts match the blocking cache's 16B memory port.
package lab3_mem_line_mem_responder_pkg;

    localparam int clw = 128;
    localparam int abw = 32;

    localparam logic [2:0] MEM_READ  = 3'd0;
    localparam logic [2:0] MEM_WRITE = 3'd1;
    localparam logic [2:0] MEM_INIT  = 3'd2;

    typedef struct packed {
        logic [2:0]     type_;
        logic [7:0]     opaque;
        logic [abw-1:0] addr;
        logic [3:0]     len;
        logic [clw-1:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]     type_;
        logic [7:0]     opaque;
        logic [1:0]     test;
        logic [3:0]     len;
        logic [clw-1:0] data;
    } mem_resp_16B_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } ctrl_state_e;

    function automatic logic is_line_write(input logic [2:0] t);
        return (t == MEM_WRITE) || (t == MEM_INIT);
    endfunction

endpackage

// File: rtl/lab3_mem_line_mem_responder_ctrl.sv
// Handshake FSM and latency counter for the line memory responder.
// resp_go marks the edge that enters RESP, where storage is touched.
module lab3_mem_line_mem_responder_ctrl
    import lab3_mem_line_mem_responder_pkg::*;
#(
    parameter int p_latency = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic memreq_val,
    input  logic memresp_rdy,
    output logic memreq_rdy,
    output logic memresp_val,
    output logic req_go,
    output logic resp_go,
    output logic in_idle
);

    localparam logic [3:0] LAT      = 4'(p_latency);
    localparam logic       ZERO_LAT = (p_latency == 0);

    ctrl_state_e state;
    logic [3:0]  cnt;
    logic        rdy_q;
    logic        val_q;

    assign in_idle     = (state == ST_IDLE);
    assign memreq_rdy  = rdy_q;
    assign memresp_val = val_q;

    assign req_go  = !reset && in_idle && rdy_q && memreq_val;
    assign resp_go = (req_go && ZERO_LAT) ||
                     (!reset && (state == ST_WAIT) && (cnt == 4'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rdy_q <= 1'b0;
            val_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_go) begin
                        cnt   <= LAT;
                        rdy_q <= 1'b0;
                        if (ZERO_LAT) begin
                            state <= ST_RESP;
                            val_q <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_RESP;
                        val_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (memresp_rdy) begin
                        state <= ST_IDLE;
                        val_q <= 1'b0;
                        rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    rdy_q <= 1'b0;
                    val_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lab3_mem_line_mem_responder.sv
// Cycle-level 16B-line main memory behind the blocking cache.
// Accepts one request at a time and answers after p_latency wait cycles.
module lab3_mem_line_mem_responder
    import lab3_mem_line_mem_responder_pkg::*;
#(
    parameter int p_num_lines = 256,
    parameter int p_latency   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memreq_val,
    output logic          memreq_rdy,
    input  mem_req_16B_t  memreq_msg,
    output logic          memresp_val,
    input  logic          memresp_rdy,
    output mem_resp_16B_t memresp_msg
);

    localparam int IW = $clog2(p_num_lines);

    logic req_go;
    logic resp_go;
    logic in_idle;

    lab3_mem_line_mem_responder_ctrl #(
        .p_latency (p_latency)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (memreq_val),
        .memresp_rdy (memresp_rdy),
        .memreq_rdy  (memreq_rdy),
        .memresp_val (memresp_val),
        .req_go      (req_go),
        .resp_go     (resp_go),
        .in_idle     (in_idle)
    );

    logic [2:0]     type_q;
    logic [7:0]     opaque_q;
    logic [IW-1:0]  idx_q;
    logic [clw-1:0] data_q;

    always_ff @(posedge clk) begin
        if (req_go) begin
            type_q   <= memreq_msg.type_;
            opaque_q <= memreq_msg.opaque;
            idx_q    <= memreq_msg.addr[4 +: IW];
            data_q   <= memreq_msg.data;
        end
    end

    // Zero latency enters RESP on the accept edge, before the input
    // register holds the request, so the live message is used then.
    logic [2:0]     cur_type;
    logic [7:0]     cur_opaque;
    logic [IW-1:0]  cur_idx;
    logic [clw-1:0] cur_data;

    assign cur_type   = in_idle ? memreq_msg.type_         : type_q;
    assign cur_opaque = in_idle ? memreq_msg.opaque        : opaque_q;
    assign cur_idx    = in_idle ? memreq_msg.addr[4 +: IW] : idx_q;
    assign cur_data   = in_idle ? memreq_msg.data          : data_q;

    logic do_read;
    logic do_write;

    always_comb begin
        do_read  = 1'b0;
        do_write = 1'b0;
        unique case (1'b1)
            (cur_type == MEM_READ):      do_read  = 1'b1;
            is_line_write(cur_type):     do_write = 1'b1;
            default: ;
        endcase
    end

    logic [clw-1:0] mem [p_num_lines];
    logic [clw-1:0] rd_line;

    assign rd_line = mem[cur_idx];

    always_ff @(posedge clk) begin
        if (resp_go && do_write) begin
            mem[cur_idx] <= cur_data;
        end
    end

    logic [2:0]     resp_type_q;
    logic [7:0]     resp_opaque_q;
    logic [clw-1:0] resp_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_type_q   <= '0;
            resp_opaque_q <= '0;
            resp_data_q   <= '0;
        end else if (resp_go) begin
            resp_type_q   <= cur_type;
            resp_opaque_q <= cur_opaque;
            resp_data_q   <= do_read ? rd_line : '0;
        end
    end

    assign memresp_msg = '{
        type_:  resp_type_q,
        opaque: resp_opaque_q,
        test:   2'b00,
        len:    4'd0,
        data:   resp_data_q
    };

    // Offset, upper address bits and len do not affect a full-line access.
    logic unused_bits;
    assign unused_bits = ^{memreq_msg.addr, memreq_msg.len};

endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// Bench for the line memory responder: latency 2 and latency 0 instances.
// Expected responses come from a line-array model indexed by addr/16.
module tb_lab3_mem_line_mem_responder;
    import lab3_mem_line_mem_responder_pkg::*;

    localparam int NL  = 256;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_val;
    logic          req_rdy;
    mem_req_16B_t  req_msg;
    logic          resp_val;
    logic          resp_rdy;
    mem_resp_16B_t resp_msg;

    logic          rst0;
    logic          req_val0;
    logic          req_rdy0;
    mem_req_16B_t  req_msg0;
    logic          resp_val0;
    logic          resp_rdy0;
    mem_resp_16B_t resp_msg0;

    lab3_mem_line_mem_responder #(
        .p_num_lines (NL),
        .p_latency   (LAT)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .memreq_val  (req_val),
        .memreq_rdy  (req_rdy),
        .memreq_msg  (req_msg),
        .memresp_val (resp_val),
        .memresp_rdy (resp_rdy),
        .memresp_msg (resp_msg)
    );

    lab3_mem_line_mem_responder #(
        .p_num_lines (NL),
        .p_latency   (0)
    ) dut0 (
        .clk         (clk),
        .reset       (rst0),
        .memreq_val  (req_val0),
        .memreq_rdy  (req_rdy0),
        .memreq_msg  (req_msg0),
        .memresp_val (resp_val0),
        .memresp_rdy (resp_rdy0),
        .memresp_msg (resp_msg0)
    );

    int npass  = 0;
    int ntotal = 0;
    int nfail  = 0;

    logic [127:0] model  [NL];
    bit           wr_ok  [NL];
    logic [127:0] model0 [NL];

    task automatic check(input string tag,
                         input logic [159:0] obs,
                         input logic [159:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) % NL);
    endfunction

    // One transaction on the latency-2 instance, with `hold` cycles of
    // response backpressure.
    task automatic txn(input logic [2:0] t, input logic [31:0] a,
                       input logic [127:0] d, input logic [7:0] op,
                       input int hold);
        int            k;
        int            li;
        logic [127:0]  exp_d;
        mem_resp_16B_t exp_r;
        li    = line_of(a);
        exp_d = '0;
        if (t == 3'd0) exp_d = model[li];
        if (t == 3'd1 || t == 3'd2) begin
            model[li] = d;
            wr_ok[li] = 1'b1;
        end
        exp_r = '{type_: t, opaque: op, test: 2'b00, len: 4'd0, data: exp_d};
        k = 0;
        while (req_rdy !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("req_rdy_idle", req_rdy, 1);
        req_val = 1'b1;
        req_msg = '{type_: t, opaque: op, addr: a,
                    len: 4'($urandom), data: d};
        @(negedge clk);
        req_val = 1'b0;
        req_msg = '{type_: 3'($urandom), opaque: 8'($urandom),
                    addr: $urandom, len: 4'd0, data: rnd128()};
        check("req_rdy_busy", req_rdy, 0);
        k = 0;
        while (resp_val !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, LAT);
        check("resp_type", resp_msg.type_, t);
        check("resp_opaque", resp_msg.opaque, op);
        check("resp_data", resp_msg.data, exp_d);
        check("resp_msg", resp_msg, exp_r);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_val", resp_val, 1);
            check("bp_msg", resp_msg, exp_r);
            check("bp_req_rdy", req_rdy, 0);
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        check("done_val", resp_val, 0);
        check("done_req_rdy", req_rdy, 1);
    endtask

    mem_req_16B_t seq0 [8];

    initial begin
        int            k;
        int            li;
        int            r;
        logic [2:0]    t;
        logic [31:0]   a;
        logic [127:0]  exp_d;

        rst       = 1'b1;
        rst0      = 1'b1;
        req_val   = 1'b0;
        req_val0  = 1'b0;
        resp_rdy  = 1'b0;
        resp_rdy0 = 1'b1;
        req_msg   = '0;
        req_msg0  = '0;
        for (int i = 0; i < NL; i++) wr_ok[i] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_rdy", req_rdy, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_resp_msg", resp_msg, 0);
        check("rst0_req_rdy", req_rdy0, 0);
        rst  = 1'b0;
        rst0 = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", req_rdy, 1);

        // directed latency-2 traffic
        txn(MEM_INIT, 32'h1000,
            128'h0f0e0d0c_0b0a0908_07060504_03020100, 8'h11, 0);
        txn(MEM_READ, 32'h1000, rnd128(), 8'h12, 0);
        txn(MEM_WRITE, 32'h2010, {4{32'hdeadbeef}}, 8'h3a, 0);
        txn(MEM_READ, 32'h2014, rnd128(), 8'h3b, 0);
        txn(MEM_WRITE, 32'h0000_0040, rnd128(), 8'h40, 0);
        txn(MEM_READ, 32'h0000_1040, rnd128(), 8'h41, 0);
        txn(MEM_READ, 32'h2010, rnd128(), 8'h42, 5);
        txn(3'd5, 32'h2010, rnd128(), 8'h43, 1);
        txn(MEM_READ, 32'h2018, rnd128(), 8'h44, 0);

        // reset while waiting: no response may appear
        req_val = 1'b1;
        req_msg = '{type_: MEM_READ, opaque: 8'h55, addr: 32'h1000,
                    len: 4'd0, data: '0};
        @(negedge clk);
        req_val = 1'b0;
        check("mid_busy", req_rdy, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_val", resp_val, 0);
        check("mid_rst_rdy", req_rdy, 0);
        check("mid_rst_msg", resp_msg, 0);
        rst = 1'b0;
        resp_rdy = 1'b1;
        @(negedge clk);
        check("mid_post_rdy", req_rdy, 1);
        for (int i = 0; i < 5; i++) begin
            check("mid_no_resp", resp_val, 0);
            @(negedge clk);
        end
        resp_rdy = 1'b0;
        txn(MEM_READ, 32'h1000, rnd128(), 8'h56, 0);

        // latency 0, request held valid back to back
        for (int i = 0; i < 8; i++) begin
            a = {$urandom} & 32'hffff_f00f;
            a[11:4] = 8'(i % 4 + 8'h20);
            seq0[i] = '{type_: (i < 4) ? MEM_WRITE : MEM_READ,
                        opaque: 8'(i), addr: a, len: 4'd0,
                        data: rnd128()};
        end
        k = 0;
        while (req_rdy0 !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        req_val0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            li    = line_of(seq0[i].addr);
            exp_d = '0;
            if (seq0[i].type_ == MEM_READ) exp_d = model0[li];
            else model0[li] = seq0[i].data;
            req_msg0 = seq0[i];
            check("b2b_rdy", req_rdy0, 1);
            @(negedge clk);
            check("b2b_val", resp_val0, 1);
            check("b2b_busy", req_rdy0, 0);
            check("b2b_type", resp_msg0.type_, seq0[i].type_);
            check("b2b_opaque", resp_msg0.opaque, seq0[i].opaque);
            check("b2b_data", resp_msg0.data, exp_d);
            @(negedge clk);
            check("b2b_gap", resp_val0, 0);
        end
        req_val0 = 1'b0;

        // randomized traffic with aliasing addresses and backpressure
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      t = MEM_READ;
            else if (r < 6) t = MEM_WRITE;
            else if (r < 7) t = MEM_INIT;
            else            t = 3'($urandom_range(3, 7));
            a  = $urandom;
            li = line_of(a);
            if (t == MEM_READ && !wr_ok[li]) t = MEM_WRITE;
            txn(t, a, rnd128(), 8'($urandom), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
